// File: rtl/gpio_pkg.sv
// Shared constants for the APB GPIO bank: register map, FSM encoding, default ID.
package gpio_pkg;

  localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] ADDR_DIR        = 3'd1;
  localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd4;
  localparam logic [2:0] ADDR_EDGE_SEL   = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE     = 3'd6;
  localparam logic [2:0] ADDR_ID         = 3'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [7:0] GPIO_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/apb_gpio_bank_if.sv
// APB bus between the SPI-to-APB bridge (master) and the GPIO banks (slave).
interface apb_gpio_bank_if #(
  parameter int BANK_NUM    = 2,
  parameter int PDATA_WIDTH = 8,
  parameter int PADDR_WIDTH = 3
);
  logic [BANK_NUM-1:0]    g_psel;
  logic                   g_penable;
  logic                   g_pwrite;
  logic [PADDR_WIDTH-1:0] g_paddr;
  logic [PDATA_WIDTH-1:0] g_pwdata;
  logic [PDATA_WIDTH-1:0] g_prdata;
  logic                   g_pready;

  modport master (
    output g_psel, g_penable, g_pwrite, g_paddr, g_pwdata,
    input  g_prdata, g_pready
  );

  modport slave (
    input  g_psel, g_penable, g_pwrite, g_paddr, g_pwdata,
    output g_prdata, g_pready
  );
endinterface

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for asynchronous pins plus a third flop so that
// rise/fall can be decoded from the already-synchronized value.
module gpio_in_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/apb_gpio_bank.sv
// APB register bank for one 8-bit GPIO port: output/direction registers,
// synchronized inputs, per-pin edge interrupts with W1C status.
//
// state  | meaning
// IDLE   | no transfer addressed to this bank
// SETUP  | select seen, waiting for penable (wait state)
// ACCESS | pready high; write/read was performed on the entry edge
module apb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int                     BANK_ID     = 0,
  parameter int                     BANK_NUM    = 2,
  parameter int                     PDATA_WIDTH = 8,
  parameter int                     PADDR_WIDTH = 3,
  parameter logic [PDATA_WIDTH-1:0] ID_VALUE    = GPIO_ID_DEFAULT
) (
  input  logic                   g_pclk,
  input  logic                   g_preset,
  apb_gpio_bank_if.slave         apb,
  input  logic [PDATA_WIDTH-1:0] gpio_in,
  output logic [PDATA_WIDTH-1:0] gpio_out,
  output logic [PDATA_WIDTH-1:0] gpio_oe,
  output logic                   irq
);

  logic [1:0]             state, state_nxt;
  logic [PDATA_WIDTH-1:0] data_out, dir, irq_en, irq_status, edge_sel;
  logic [PDATA_WIDTH-1:0] prdata, rd_mux, w1c_mask, edge_evt;
  logic [PDATA_WIDTH-1:0] data_in, pin_rise, pin_fall;
  logic                   irq_q, sel, do_access, do_write;

  gpio_in_sync #(.WIDTH(PDATA_WIDTH)) u_sync (
    .clk  (g_pclk),
    .rst  (g_preset),
    .d    (gpio_in),
    .q    (data_in),
    .rise (pin_rise),
    .fall (pin_fall)
  );

  assign sel       = apb.g_psel[BANK_ID];
  assign do_access = (state == ST_SETUP) && sel && apb.g_penable;
  assign do_write  = do_access && apb.g_pwrite;

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = (sel && !apb.g_penable) ? ST_SETUP : ST_IDLE;
      ST_SETUP: begin
        if (!sel)                 state_nxt = ST_IDLE;
        else if (apb.g_penable)   state_nxt = ST_ACCESS;
        else                      state_nxt = ST_SETUP;
      end
      ST_ACCESS: state_nxt = (sel && !apb.g_penable) ? ST_SETUP : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (apb.g_paddr)
      ADDR_DATA_OUT:   rd_mux = data_out;
      ADDR_DIR:        rd_mux = dir;
      ADDR_DATA_IN:    rd_mux = data_in;
      ADDR_IRQ_EN:     rd_mux = irq_en;
      ADDR_IRQ_STATUS: rd_mux = irq_status;
      ADDR_EDGE_SEL:   rd_mux = edge_sel;
      ADDR_TOGGLE:     rd_mux = '0;
      ADDR_ID:         rd_mux = ID_VALUE;
      default:         rd_mux = '0;
    endcase
  end

  // A new edge event on a bit wins over a same-cycle W1C clear of that bit.
  assign w1c_mask = (do_write && apb.g_paddr == ADDR_IRQ_STATUS) ? apb.g_pwdata : '0;
  assign edge_evt = (edge_sel & pin_rise) | (~edge_sel & pin_fall);

  always_ff @(posedge g_pclk) begin
    if (g_preset) begin
      state      <= ST_IDLE;
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      irq_status <= '0;
      edge_sel   <= '0;
      prdata     <= '0;
      irq_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      irq_status <= (irq_status & ~w1c_mask) | edge_evt;
      irq_q      <= |(irq_status & irq_en);
      if (do_write) begin
        case (apb.g_paddr)
          ADDR_DATA_OUT: data_out <= apb.g_pwdata;
          ADDR_DIR:      dir      <= apb.g_pwdata;
          ADDR_IRQ_EN:   irq_en   <= apb.g_pwdata;
          ADDR_EDGE_SEL: edge_sel <= apb.g_pwdata;
          ADDR_TOGGLE:   data_out <= data_out ^ apb.g_pwdata;
          default: ;
        endcase
      end else if (do_access) begin
        prdata <= rd_mux;
      end
    end
  end

  assign apb.g_pready = (state == ST_ACCESS);
  assign apb.g_prdata = prdata;
  assign gpio_out     = data_out;
  assign gpio_oe      = dir;
  assign irq          = irq_q;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank instantiated as bank 1 of 2.
module tb_apb_gpio_bank;
  import gpio_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gpio_in = '0;
  logic [7:0] gpio_out, gpio_oe;
  logic       irq;

  int errors = 0;
  int checks = 0;

  apb_gpio_bank_if #(.BANK_NUM(2), .PDATA_WIDTH(8), .PADDR_WIDTH(3)) bus ();

  apb_gpio_bank #(
    .BANK_ID(1), .BANK_NUM(2), .PDATA_WIDTH(8), .PADDR_WIDTH(3), .ID_VALUE(8'hA5)
  ) dut (
    .g_pclk   (clk),
    .g_preset (rst),
    .apb      (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One APB transfer; returns read data, number of pready cycles seen and
  // gpio_out as observed in the pready cycle.
  task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                          input logic [1:0] psel, output logic [7:0] rd,
                          output int rdy_cnt, output logic [7:0] out_at_rdy);
    rdy_cnt = 0;
    rd = '0;
    out_at_rdy = '0;
    @(negedge clk);
    bus.g_psel = psel; bus.g_penable = 1'b0; bus.g_pwrite = wr;
    bus.g_paddr = addr; bus.g_pwdata = wd;
    @(negedge clk);
    bus.g_penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.g_pready) begin
        rdy_cnt++;
        rd = bus.g_prdata;
        out_at_rdy = gpio_out;
        bus.g_psel = '0;
        bus.g_penable = 1'b0;
      end
    end
    bus.g_psel = '0;
    bus.g_penable = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [2:0] addr, input logic [7:0] wd);
    logic [7:0] rd, o;
    int n;
    apb_xfer(1'b1, addr, wd, 2'b10, rd, n, o);
    check_val({tag, "_rdy"}, n, 1);
  endtask

  task automatic rd_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp_v);
    logic [7:0] rd, o;
    int n;
    apb_xfer(1'b0, addr, 8'h00, 2'b10, rd, n, o);
    check_val({tag, "_rdy"}, n, 1);
    check_val(tag, rd, exp_v);
  endtask

  initial begin
    logic [7:0] rd, o;
    int n;
    bus.g_psel = '0; bus.g_penable = 1'b0; bus.g_pwrite = 1'b0;
    bus.g_paddr = '0; bus.g_pwdata = '0;

    repeat (3) @(negedge clk);
    check_val("rst_out", gpio_out, 8'h00);
    check_val("rst_oe", gpio_oe, 8'h00);
    check_val("rst_irq", irq, 0);
    check_val("rst_pready", bus.g_pready, 0);
    check_val("rst_prdata", bus.g_prdata, 8'h00);
    rst = 1'b0;

    for (int a = 0; a < 8; a++)
      rd_reg($sformatf("rst_rd%0d", a), 3'(a), (a == 7) ? 8'hA5 : 8'h00);

    // Output and direction registers, then toggle.
    apb_xfer(1'b1, ADDR_DIR, 8'hF0, 2'b10, rd, n, o);
    check_val("dir_rdy", n, 1);
    check_val("dir_oe", gpio_oe, 8'hF0);
    apb_xfer(1'b1, ADDR_DATA_OUT, 8'h3C, 2'b10, rd, n, o);
    check_val("dout_at_rdy", o, 8'h3C);
    apb_xfer(1'b1, ADDR_TOGGLE, 8'hFF, 2'b10, rd, n, o);
    check_val("toggle_at_rdy", o, 8'hC3);
    rd_reg("toggle_rd0", ADDR_TOGGLE, 8'h00);
    rd_reg("dout_rd", ADDR_DATA_OUT, 8'hC3);
    wr_reg("id_wr", ADDR_ID, 8'h00);
    rd_reg("id_ro", ADDR_ID, 8'hA5);

    // Bank select decode.
    apb_xfer(1'b1, ADDR_DATA_OUT, 8'h55, 2'b01, rd, n, o);
    check_val("othersel_rdy", n, 0);
    check_val("othersel_out", gpio_out, 8'hC3);
    apb_xfer(1'b1, ADDR_DATA_OUT, 8'h55, 2'b10, rd, n, o);
    check_val("sel_rdy", n, 1);
    check_val("sel_out", gpio_out, 8'h55);

    // Edge interrupts: pin0 rising-sensitive, pin1 falling-sensitive.
    wr_reg("esel_wr", ADDR_EDGE_SEL, 8'h01);
    wr_reg("ien_wr", ADDR_IRQ_EN, 8'h03);
    @(negedge clk);
    gpio_in = 8'h03;
    repeat (3) @(negedge clk);
    check_val("irq_pre", irq, 0);
    @(negedge clk);
    check_val("irq_rise", irq, 1);
    rd_reg("datain", ADDR_DATA_IN, 8'h03);
    rd_reg("stat_rise", ADDR_IRQ_STATUS, 8'h01);
    gpio_in = 8'h01;
    repeat (5) @(negedge clk);
    rd_reg("stat_fall", ADDR_IRQ_STATUS, 8'h03);

    // Pin0 falls (no event for a rising-sensitive pin); esel change no event.
    gpio_in = 8'h00;
    repeat (5) @(negedge clk);
    wr_reg("esel_wr2", ADDR_EDGE_SEL, 8'h03);
    wr_reg("esel_wr3", ADDR_EDGE_SEL, 8'h01);
    rd_reg("stat_nochg", ADDR_IRQ_STATUS, 8'h03);

    // W1C of bit0 on the same edge that detects a new rise on pin0.
    @(negedge clk);
    gpio_in = 8'h01;
    wr_reg("w1c_race", ADDR_IRQ_STATUS, 8'h01);
    rd_reg("stat_setwins", ADDR_IRQ_STATUS, 8'h03);
    check_val("irq_before_clr", irq, 1);
    wr_reg("w1c_all", ADDR_IRQ_STATUS, 8'h03);
    rd_reg("stat_clr", ADDR_IRQ_STATUS, 8'h00);
    check_val("irq_clr", irq, 0);

    // Reset during SETUP of a write.
    @(negedge clk);
    bus.g_psel = 2'b10; bus.g_penable = 1'b0; bus.g_pwrite = 1'b1;
    bus.g_paddr = ADDR_DATA_OUT; bus.g_pwdata = 8'hAA;
    @(negedge clk);
    bus.g_penable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.g_pready) n++;
    end
    check_val("rstmid_rdy", n, 0);
    check_val("rstmid_out", gpio_out, 8'h00);
    check_val("rstmid_oe", gpio_oe, 8'h00);
    bus.g_psel = '0; bus.g_penable = 1'b0;
    apb_xfer(1'b1, ADDR_DATA_OUT, 8'h5A, 2'b10, rd, n, o);
    check_val("post_rst_rdy", n, 1);
    check_val("post_rst_out", gpio_out, 8'h5A);
    rd_reg("post_rst_rd", ADDR_DATA_OUT, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/apb_gpio_bank.md
Name: apb_gpio_bank

Overview:
- APB slave register bank for one 8-bit GPIO port of the expander; sits directly downstream of spi2apb_bridge and consumes its APB transactions.
- Bridge drives one psel bit per bank; each instance decodes its own bit (BANK_ID).
- Provides output/direction registers, synchronized input sampling, per-pin edge interrupt with W1C status, and a registered one-wait-state pready.

Parameters:
- BANK_ID, 0, index of the g_psel bit this instance responds to
- BANK_NUM, 2, width of g_psel bus
- PDATA_WIDTH, 8, data width and GPIO pin count
- PADDR_WIDTH, 3, register address width
- ID_VALUE, 8'hA5, constant returned by the ID register

Ports:
- g_pclk  in  1  APB clock, sole clock
- g_preset  in  1  synchronous active-high reset
- g_psel  in  BANK_NUM  bank selects from bridge
- g_penable  in  1  APB access phase
- g_pwrite  in  1  1 = write, 0 = read
- g_paddr  in  PADDR_WIDTH  register address
- g_pwdata  in  PDATA_WIDTH  write data
- g_prdata  out  PDATA_WIDTH  read data, valid while g_pready = 1
- g_pready  out  1  transfer-complete strobe
- gpio_in  in  PDATA_WIDTH  asynchronous pin inputs
- gpio_out  out  PDATA_WIDTH  pin output values
- gpio_oe  out  PDATA_WIDTH  per-pin output enable (1 = drive)
- irq  out  1  level interrupt = |(IRQ_STATUS & IRQ_EN)

Behaviour:
- Reset (g_preset = 1 at a g_pclk edge): all registers 0; g_prdata = 0, g_pready = 0, gpio_out = 0, gpio_oe = 0, irq = 0; synchronizer flops 0; FSM to IDLE.
- Reset wins over any in-flight transfer. The transfer is dropped and no register is written.
- Register map:
  - 0 DATA_OUT (RW)
  - 1 DIR (RW; drives gpio_oe)
  - 2 DATA_IN (RO; synchronized pins)
  - 3 IRQ_EN (RW)
  - 4 IRQ_STATUS (RO/W1C)
  - 5 EDGE_SEL (RW; per pin, 1 = rising, 0 = falling)
  - 6 TOGGLE (WO; DATA_OUT ^= g_pwdata; reads 0)
  - 7 ID (RO; ID_VALUE)
- Writes to RO addresses are ignored.
- sel = g_psel[BANK_ID].
- FSM states and transitions:
  - IDLE: go to SETUP when sel & !g_penable.
  - SETUP: go to ACCESS when sel & g_penable; go back to IDLE if sel drops.
  - ACCESS: assert g_pready for exactly one cycle. Perform the write, or register g_prdata, on the entry edge. Return to IDLE on the next edge, or to SETUP if sel & !g_penable.
- Latency: g_pready rises 1 cycle after g_penable is first seen high (one wait state).
- g_prdata holds its last value outside ACCESS.
- A write takes effect on the edge that asserts g_pready.
- Input path: 2-flop synchronizer, then a third flop for edge detect.
  - DATA_IN = second stage output.
  - Latency from a pin change to DATA_IN: 2 cycles. Latency to IRQ_STATUS set: 3 cycles.
- Edge event: pin i with EDGE_SEL[i] = 1 sets on a 0→1 transition; EDGE_SEL[i] = 0 sets on a 1→0 transition.
- IRQ_STATUS[i] is set on an edge event regardless of IRQ_EN; IRQ_EN masks irq only.
- Same-cycle W1C clear and new event on the same bit: set wins.
- irq is registered and follows IRQ_STATUS & IRQ_EN one cycle later.
- Changing EDGE_SEL does not itself generate an event.
- Both stable 8-bit fields; no arithmetic beyond XOR.
- Unselected banks ignore the bus entirely and keep g_pready = 0.

Decomposition:
- Shared package gpio_pkg:
  - Register address constants (ADDR_DATA_OUT … ADDR_ID)
  - FSM state encoding (IDLE/SETUP/ACCESS)
  - Default ID_VALUE
- One sub-module, gpio_in_sync: parameterized-width 3-flop synchronizer. Outputs sync value and rise/fall vectors; synchronous active-high reset.

Test Plan:
- Reset then read all 8 addresses -> 0 everywhere except ID, which reads 8'hA5; g_pready high exactly 1 cycle per read.
- Write DIR = 8'hF0 then DATA_OUT = 8'h3C -> gpio_oe = 8'hF0, gpio_out = 8'h3C on the pready edge; TOGGLE write 8'hFF -> gpio_out = 8'hC3.
- With BANK_ID = 1, a transfer with g_psel = 2'b01 writing 8'h55 to DATA_OUT -> no g_pready, gpio_out unchanged; g_psel = 2'b10 -> gpio_out = 8'h55.
- EDGE_SEL = 8'h01, IRQ_EN = 8'h03; gpio_in[0] 0→1 and gpio_in[1] 0→1 -> IRQ_STATUS = 8'h01 after 3 cycles and irq = 1; gpio_in[1] 1→0 -> IRQ_STATUS = 8'h03.
- W1C write 8'h01 to IRQ_STATUS in the same cycle a new rise on pin 0 is detected -> bit 0 stays 1. Then write 8'h03 with no event -> IRQ_STATUS = 0 and irq = 0 one cycle later.
- Assert g_preset during SETUP of a write of 8'hAA to DATA_OUT -> gpio_out stays 0, FSM in IDLE, g_pready never asserts; the next normal transfer completes correctly.
